// File: rtl/oam_dma.sv
// Sprite DMA: on a CPU store to DMA_REG, halts the core and copies one 256-byte
// page to the PPU OAM data port as alternating read/write bus cycles.
module oam_dma #(
    parameter logic [15:0] DMA_REG  = 16'h4014,
    parameter logic [15:0] OAM_DATA = 16'h2004
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_write,
    input  logic [7:0]  cpu_d_out,
    input  logic [7:0]  d_in,
    output logic        cpu_ready,
    output logic        dma_active,
    output logic [15:0] dma_addr,
    output logic        dma_write,
    output logic [7:0]  dma_d_out
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HALT  = 3'd1,
        ALIGN = 3'd2,
        READ  = 3'd3,
        WRITE = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic        parity_q;
    logic [7:0]  page_q, page_d;
    logic [7:0]  idx_q, idx_d;
    logic [7:0]  buf_q, buf_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            parity_q <= 1'b0;
            page_q   <= 8'h00;
            idx_q    <= 8'h00;
            buf_q    <= 8'h00;
        end else begin
            state_q  <= state_d;
            parity_q <= ~parity_q;
            page_q   <= page_d;
            idx_q    <= idx_d;
            buf_q    <= buf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        page_d  = page_q;
        idx_d   = idx_q;
        buf_d   = buf_q;
        unique case (state_q)
            IDLE: begin
                if (cpu_write && (cpu_addr == DMA_REG)) begin
                    state_d = HALT;
                    page_d  = cpu_d_out;
                    idx_d   = 8'h00;
                end
            end
            // An odd cycle in HALT costs one extra dummy cycle before the first read.
            HALT:  state_d = parity_q ? ALIGN : READ;
            ALIGN: state_d = READ;
            READ: begin
                buf_d   = d_in;
                state_d = WRITE;
            end
            WRITE: begin
                if (idx_q == 8'hFF) begin
                    state_d = IDLE;
                end else begin
                    idx_d   = idx_q + 8'd1;
                    state_d = READ;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs depend only on registered state, never directly on inputs.
    always_comb begin
        cpu_ready  = (state_q == IDLE);
        dma_active = (state_q != IDLE);
        dma_addr   = 16'h0000;
        dma_write  = 1'b0;
        dma_d_out  = 8'h00;
        case (state_q)
            READ: begin
                dma_addr = {page_q, idx_q};
            end
            WRITE: begin
                dma_addr  = OAM_DATA;
                dma_write = 1'b1;
                dma_d_out = buf_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_oam_dma.sv
// Bench for oam_dma: bus memory model, per-cycle bus trace capture and
// comparison against the expected HALT/ALIGN/READ/WRITE cycle sequence.
module tb_oam_dma;

    logic        clk;
    logic        reset;
    logic [15:0] cpu_addr;
    logic        cpu_write;
    logic [7:0]  cpu_d_out;
    logic [7:0]  d_in;
    logic        cpu_ready;
    logic        dma_active;
    logic [15:0] dma_addr;
    logic        dma_write;
    logic [7:0]  dma_d_out;

    oam_dma dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_addr   (cpu_addr),
        .cpu_write  (cpu_write),
        .cpu_d_out  (cpu_d_out),
        .d_in       (d_in),
        .cpu_ready  (cpu_ready),
        .dma_active (dma_active),
        .dma_addr   (dma_addr),
        .dma_write  (dma_write),
        .dma_d_out  (dma_d_out)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Zero-wait-state memory on the shared bus
    logic [7:0]  mem [0:65535];
    logic [15:0] bus_a;
    assign bus_a = dma_active ? dma_addr : cpu_addr;
    assign d_in  = mem[bus_a];

    // Free-running parity as seen by the engine: toggles every clock out of reset
    logic m_par;
    always @(posedge clk or negedge reset) begin
        if (!reset) m_par <= 1'b0;
        else        m_par <= ~m_par;
    end

    // Trace entry: {addr[15:0], write, data[7:0]}
    localparam int W = 25;
    logic [W-1:0] obs_q[$];
    logic [W-1:0] exp_q[$];
    bit           exp_dchk_q[$];
    int           halt_cnt;
    int           wr_cnt;
    int           active_cnt;
    int           bad_ready_cnt;
    int           bad_idle_cnt;

    int checks;
    int failures;

    always @(negedge clk) begin
        if (reset) begin
            if (dma_active) begin
                obs_q.push_back({dma_addr, dma_write, dma_d_out});
                active_cnt++;
                if (dma_write) wr_cnt++;
            end else if (dma_addr !== 16'h0 || dma_write !== 1'b0 || dma_d_out !== 8'h0) begin
                bad_idle_cnt++;
            end
            if (!cpu_ready) halt_cnt++;
            if (cpu_ready !== !dma_active) bad_ready_cnt++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_obs();
        obs_q.delete();
        halt_cnt   = 0;
        wr_cnt     = 0;
        active_cnt = 0;
    endtask

    // Expected bus cycles: one HALT, an ALIGN if HALT is odd, then 256 read/write pairs.
    task automatic build_expected(input logic [7:0] page, input bit par);
        exp_q.delete();
        exp_dchk_q.delete();
        exp_q.push_back({16'h0000, 1'b0, 8'h00}); exp_dchk_q.push_back(1'b1);
        if (par) begin
            exp_q.push_back({16'h0000, 1'b0, 8'h00}); exp_dchk_q.push_back(1'b1);
        end
        for (int i = 0; i < 256; i++) begin
            exp_q.push_back({page, i[7:0], 1'b0, 8'h00});               exp_dchk_q.push_back(1'b0);
            exp_q.push_back({16'h2004, 1'b1, mem[{page, i[7:0]}]});     exp_dchk_q.push_back(1'b1);
        end
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (dma_active === 1'b1 && n < 700) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_done"}, {31'd0, dma_active}, 32'd0);
    endtask

    task automatic compare_trace(input string tag);
        int n;
        int bad;
        logic [W-1:0] o, e;
        chk({tag, "_len"}, obs_q.size(), exp_q.size());
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        bad = 0;
        for (int j = 0; j < n; j++) begin
            o = obs_q[j];
            e = exp_q[j];
            if (!exp_dchk_q[j]) begin
                o[7:0] = 8'h00;
                e[7:0] = 8'h00;
            end
            if (o !== e && bad < 4) begin
                chk($sformatf("%s_cyc%0d", tag, j), {7'd0, o}, {7'd0, e});
                bad++;
            end
        end
        chk({tag, "_trace_mismatches"}, bad, 0);
    endtask

    // Trigger a transfer with HALT landing on the requested parity.
    task automatic do_dma(input string tag, input logic [7:0] page, input bit want_par);
        bit p;
        @(negedge clk);
        if (m_par == want_par) @(negedge clk);
        p = ~m_par;
        clear_obs();
        build_expected(page, p);
        cpu_addr  = 16'h4014;
        cpu_write = 1'b1;
        cpu_d_out = page;
        @(posedge clk);
        #1;
        chk({tag, "_ready_fall"}, {31'd0, cpu_ready}, 32'd0);
        cpu_write = 1'b0;
        cpu_addr  = 16'h0000;
        cpu_d_out = 8'h00;
        @(negedge clk);
        wait_idle(tag);
        chk({tag, "_halt_len"}, halt_cnt, 513 + int'(p));
        chk({tag, "_writes"}, wr_cnt, 256);
        compare_trace(tag);
        chk({tag, "_ready_back"}, {31'd0, cpu_ready}, 32'd1);
    endtask

    task automatic cpu_wr(input logic [15:0] a, input logic [7:0] d, input logic w);
        @(negedge clk);
        cpu_addr  = a;
        cpu_d_out = d;
        cpu_write = w;
        @(negedge clk);
        cpu_write = 1'b0;
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        bad_ready_cnt = 0;
        bad_idle_cnt  = 0;
        clear_obs();
        for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
        for (int i = 0; i < 256; i++) mem[16'h0200 + i] = 8'(i) ^ 8'h5A;

        // Reset held while a trigger write is presented
        reset     = 1'b0;
        cpu_addr  = 16'h4014;
        cpu_write = 1'b1;
        cpu_d_out = 8'h05;
        repeat (4) @(negedge clk);
        chk("rst_ready",  {31'd0, cpu_ready},  32'd1);
        chk("rst_active", {31'd0, dma_active}, 32'd0);
        chk("rst_addr",   {16'd0, dma_addr},   32'd0);
        chk("rst_write",  {31'd0, dma_write},  32'd0);
        chk("rst_dout",   {24'd0, dma_d_out},  32'd0);
        cpu_write = 1'b0;
        cpu_addr  = 16'h0000;
        #2 reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("post_rst_ready",  {31'd0, cpu_ready},  32'd1);
        chk("post_rst_active", {31'd0, dma_active}, 32'd0);

        do_dma("even_p02", 8'h02, 1'b0);
        do_dma("odd_p02",  8'h02, 1'b1);
        do_dma("page_ff",  8'hFF, 1'($urandom_range(0, 1)));
        repeat (3) @(negedge clk);
        chk("page_ff_quiet", active_cnt, 514 - 1 + int'(exp_q.size() == 514));

        // Reset after the 100th OAM write
        begin
            int n;
            clear_obs();
            cpu_wr(16'h4014, 8'h07, 1'b1);
            n = 0;
            while (wr_cnt < 100 && n < 400) begin
                @(negedge clk);
                #1;
                n++;
            end
            chk("mid_wr_reached", wr_cnt, 100);
            #1 reset = 1'b0;
            #1;
            chk("mid_active", {31'd0, dma_active}, 32'd0);
            chk("mid_ready",  {31'd0, cpu_ready},  32'd1);
            chk("mid_write",  {31'd0, dma_write},  32'd0);
            repeat (3) @(negedge clk);
            #2 reset = 1'b1;
            repeat (3) @(negedge clk);
            chk("mid_no_more_writes", wr_cnt, 100);
            chk("mid_idle_after", {31'd0, dma_active}, 32'd0);
        end
        do_dma("after_rst_p03", 8'h03, 1'($urandom_range(0, 1)));

        // Non-trigger bus activity
        clear_obs();
        cpu_wr(16'h4013, 8'h11, 1'b1);
        cpu_wr(16'h4015, 8'h22, 1'b1);
        cpu_wr(16'h2014, 8'h33, 1'b1);
        cpu_wr(16'h4014, 8'h44, 1'b0);
        repeat (4) @(negedge clk);
        chk("nontrig_active_cycles", active_cnt, 0);
        chk("nontrig_halt_cycles",   halt_cnt,   0);

        // Random pages and parities
        for (int k = 0; k < 2; k++) begin
            do_dma($sformatf("rand%0d", k), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 5)) @(negedge clk);
        end

        chk("ready_vs_active", bad_ready_cnt, 0);
        chk("idle_outputs",    bad_idle_cnt,  0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
